// File: rtl/selector_counter_autorepeat.sv
// Up/down selector counter driven by two active-low push-buttons, with press-edge
// stepping, hold-to-auto-repeat, wrap/saturate bounds, preset load and status flags.
module selector_counter_autorepeat #(
  parameter int unsigned SIZE_COUNT    = 8,
  parameter int unsigned MIN_VAL       = 0,
  parameter int unsigned MAX_VAL       = 2**SIZE_COUNT-1,
  parameter int unsigned STEP          = 1,
  parameter int unsigned WRAP          = 1,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned HOLD_DELAY    = 50,
  parameter int unsigned REPEAT_PERIOD = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sum,
  input  logic                  rest,
  input  logic                  load,
  input  logic [SIZE_COUNT-1:0] load_val,
  output logic [SIZE_COUNT-1:0] valor,
  output logic                  at_max,
  output logic                  at_min,
  output logic                  changed
);

  typedef logic [SIZE_COUNT:0] wide_t;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

  localparam wide_t MIN_W  = wide_t'(MIN_VAL);
  localparam wide_t MAX_W  = wide_t'(MAX_VAL);
  localparam wide_t STEP_W = wide_t'(STEP);
  localparam wide_t LIM_HI = MAX_W - STEP_W;
  localparam wide_t LIM_LO = MIN_W + STEP_W;
  localparam logic [SIZE_COUNT-1:0] MIN_V  = SIZE_COUNT'(MIN_VAL);
  localparam logic [SIZE_COUNT-1:0] MAX_V  = SIZE_COUNT'(MAX_VAL);
  localparam logic [SIZE_COUNT-1:0] STEP_V = SIZE_COUNT'(STEP);
  localparam int unsigned CNT_TOP = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW      = $clog2(CNT_TOP + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_DELAY);
  localparam logic [CW-1:0] REP_C  = CW'(REPEAT_PERIOD);

  logic [SYNC_STAGES-1:0] sum_sync_q, rest_sync_q, fill_q;
  logic                   up_prev_q, dn_prev_q;
  logic                   su, re, up_lone, dn_lone, up_edge, dn_edge, held;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   dir_q, dir_d, step_q, step_d, step_up_q, locked_q, locked_d;

  logic [SIZE_COUNT-1:0]  valor_q, valor_d, stepped;
  logic                   changed_q, changed_d;
  wide_t                  cur_w, ld_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_sync_q  <= '1;
      rest_sync_q <= '1;
      fill_q      <= '0;
      up_prev_q   <= 1'b0;
      dn_prev_q   <= 1'b0;
    end else begin
      sum_sync_q  <= {sum_sync_q[SYNC_STAGES-2:0], sum};
      rest_sync_q <= {rest_sync_q[SYNC_STAGES-2:0], rest};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      up_prev_q   <= up_lone;
      dn_prev_q   <= dn_lone;
    end
  end

  // Edges are taken on the "exactly one button" level, so leaving a conflict or
  // swapping buttons directly both register as a fresh press.
  assign su      = ~sum_sync_q[SYNC_STAGES-1];
  assign re      = ~rest_sync_q[SYNC_STAGES-1];
  assign up_lone = su & ~re;
  assign dn_lone = re & ~su;
  assign up_edge = up_lone & ~up_prev_q;
  assign dn_edge = dn_lone & ~dn_prev_q;
  assign held    = dir_q ? up_lone : dn_lone;
  assign cnt_inc = cnt_q + CW'(1);

  // After reset the synchroniser reads "released"; stay locked until real samples
  // show both buttons up, so a button held through reset never steps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    locked_d = locked_q & ~(fill_q[SYNC_STAGES-1] & ~su & ~re);
    if (locked_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (up_edge || dn_edge) begin
      step_d  = 1'b1;
      dir_d   = up_edge;
      cnt_d   = '0;
      state_d = HOLD;
    end else if (state_q != IDLE && held) begin
      if ((state_q == HOLD && cnt_inc == HOLD_C) || (state_q == REPEAT && cnt_inc == REP_C)) begin
        step_d  = 1'b1;
        cnt_d   = '0;
        state_d = REPEAT;
      end else begin
        cnt_d = cnt_inc;
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    cur_w   = {1'b0, valor_q};
    ld_w    = {1'b0, load_val};
    stepped = valor_q;
    if (step_up_q) begin
      if (cur_w <= LIM_HI) stepped = valor_q + STEP_V;
      else                 stepped = (WRAP != 0) ? MIN_V : MAX_V;
    end else begin
      if (cur_w >= LIM_LO) stepped = valor_q - STEP_V;
      else                 stepped = (WRAP != 0) ? MAX_V : MIN_V;
    end
    valor_d = valor_q;
    if (load) begin
      if (ld_w < MIN_W)      valor_d = MIN_V;
      else if (ld_w > MAX_W) valor_d = MAX_V;
      else                   valor_d = load_val;
    end else if (step_q) begin
      valor_d = stepped;
    end
    changed_d = (valor_d != valor_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      step_up_q <= 1'b0;
      locked_q  <= 1'b1;
      valor_q   <= MIN_V;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      step_up_q <= dir_d;
      locked_q  <= locked_d;
      valor_q   <= valor_d;
      changed_q <= changed_d;
    end
  end

  assign valor   = valor_q;
  assign changed = changed_q;
  assign at_max  = (valor_q == MAX_V);
  assign at_min  = (valor_q == MIN_V);

endmodule
